// File: rtl/frame_decoder.sv
// frame_decoder: receive end of the Pong map link.
// Takes a gap-aligned byte stream of MAP_HEIGHT x MAP_WIDTH chars, row-major.
// Each char becomes a pixel write. Every frame is checked for legal chars and for full length.
// Optional feature: define PIXEL_COUNT_EN to report, on lit_count, the number of lit pixels
// in the last completed frame. Without it, lit_count is tied to 0.
module frame_decoder #(
  parameter int         MAP_HEIGHT  = 24,
  parameter int         MAP_WIDTH   = 80,
  parameter logic [7:0] CHAR_ON     = 8'hB2,
  parameter logic [7:0] CHAR_OFF    = 8'h20,
  parameter int         IDLE_CYCLES = 20000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        pix_we,
  output logic [7:0]  pix_row,
  output logic [7:0]  pix_col,
  output logic        pix_val,
  output logic        frame_done,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic [7:0]  frame_count,
  output logic        in_frame,
  output logic [11:0] lit_count
);

  localparam int               GAP_W       = $clog2(IDLE_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'(IDLE_CYCLES);
  localparam logic [7:0]       LAST_ROW    = 8'(MAP_HEIGHT - 1);
  localparam logic [7:0]       LAST_COL    = 8'(MAP_WIDTH - 1);
  localparam logic [1:0]       ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]       ERR_SHORT   = 2'b10;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    READY = 2'd1,
    RECV  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [7:0]       row_q, row_d;
  logic [7:0]       col_q, col_d;
  logic             pix_we_q, pix_we_d;
  logic [7:0]       pix_row_q, pix_row_d;
  logic [7:0]       pix_col_q, pix_col_d;
  logic             pix_val_q, pix_val_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q, frame_err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [7:0]       frame_count_q, frame_count_d;
  logic             in_frame_q, in_frame_d;

  logic       gap_met;
  logic       is_on;
  logic       is_legal;
  logic       pix_accept;
  logic       at_last;
  logic [7:0] cur_row;
  logic [7:0] cur_col;

  assign gap_met    = (gap_q == GAP_MAX);
  assign is_on      = (rx_data == CHAR_ON);
  assign is_legal   = is_on || (rx_data == CHAR_OFF);
  assign pix_accept = rx_valid && is_legal && (state_q != SYNC);
  // A byte arriving in READY is always the first pixel of a new frame.
  assign cur_row    = (state_q == RECV) ? row_q : 8'd0;
  assign cur_col    = (state_q == RECV) ? col_q : 8'd0;
  assign at_last    = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
  assign in_frame_d = (state_d == RECV);

  // Idle-gap counter: any byte restarts it; it saturates at the threshold.
  always_comb begin
    gap_d = gap_q;
    if (rx_valid) begin
      gap_d = '0;
    end else if (!gap_met) begin
      gap_d = gap_q + GAP_W'(1);
    end
  end

  // Frame alignment and decode: next state, position and registered output values.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    pix_we_d      = 1'b0;
    pix_row_d     = pix_row_q;
    pix_col_d     = pix_col_q;
    pix_val_d     = pix_val_q;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    err_code_d    = err_code_q;
    frame_count_d = frame_count_q;
    case (state_q)
      SYNC: begin
        row_d = 8'd0;
        col_d = 8'd0;
        // A byte on the threshold cycle keeps us out of alignment.
        if (gap_met && !rx_valid) begin
          state_d = READY;
        end
      end
      READY, RECV: begin
        if (rx_valid) begin
          if (is_legal) begin
            pix_we_d  = 1'b1;
            pix_row_d = cur_row;
            pix_col_d = cur_col;
            pix_val_d = is_on;
            if (at_last) begin
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 8'd1;
              state_d       = READY;
              row_d         = 8'd0;
              col_d         = 8'd0;
            end else begin
              state_d = RECV;
              if (cur_col == LAST_COL) begin
                col_d = 8'd0;
                row_d = cur_row + 8'd1;
              end else begin
                col_d = cur_col + 8'd1;
                row_d = cur_row;
              end
            end
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ERR_ILLEGAL;
            state_d     = SYNC;
          end
        end else if ((state_q == RECV) && gap_met) begin
          // The link went quiet mid-frame. The gap is already met, so the next byte starts a new frame.
          frame_err_d = 1'b1;
          err_code_d  = ERR_SHORT;
          state_d     = READY;
          row_d       = 8'd0;
          col_d       = 8'd0;
        end
      end
      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State, position, gap counter and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= SYNC;
      gap_q         <= '0;
      row_q         <= 8'd0;
      col_q         <= 8'd0;
      pix_we_q      <= 1'b0;
      pix_row_q     <= 8'd0;
      pix_col_q     <= 8'd0;
      pix_val_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      err_code_q    <= 2'b00;
      frame_count_q <= 8'd0;
      in_frame_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      row_q         <= row_d;
      col_q         <= col_d;
      pix_we_q      <= pix_we_d;
      pix_row_q     <= pix_row_d;
      pix_col_q     <= pix_col_d;
      pix_val_q     <= pix_val_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      err_code_q    <= err_code_d;
      frame_count_q <= frame_count_d;
      in_frame_q    <= in_frame_d;
    end
  end

  assign pix_we      = pix_we_q;
  assign pix_row     = pix_row_q;
  assign pix_col     = pix_col_q;
  assign pix_val     = pix_val_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign err_code    = err_code_q;
  assign frame_count = frame_count_q;
  assign in_frame    = in_frame_q;

`ifdef PIXEL_COUNT_EN
  logic [11:0] lit_acc_q, lit_acc_d;
  logic [11:0] lit_count_q, lit_count_d;

  // Lit-pixel accumulator. It restarts on the first pixel of a frame and is published on frame_done.
  always_comb begin
    lit_acc_d   = lit_acc_q;
    lit_count_d = lit_count_q;
    if (pix_accept) begin
      lit_acc_d = ((state_q == READY) ? 12'd0 : lit_acc_q) + {11'd0, is_on};
      if (frame_done_d) begin
        lit_count_d = lit_acc_d;
      end
    end
  end

  // Lit-pixel registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      lit_acc_q   <= 12'd0;
      lit_count_q <= 12'd0;
    end else begin
      lit_acc_q   <= lit_acc_d;
      lit_count_q <= lit_count_d;
    end
  end

  assign lit_count = lit_count_q;
`else
  assign lit_count = 12'd0;
`endif

endmodule
